// File: rtl/serial_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : serial_pattern_gen
// Brief    : Table-driven serial pattern generator. Shifts one WIDTH-bit
//            pattern out per frame. Define SPG_MSB_FIRST_EN for MSB-first order.
// Revision : 1.0 - initial release
// ============================================================================
module serial_pattern_gen #(
    parameter  int WIDTH  = 8,
    parameter  int ADDR_W = 3,
    localparam int CNT_W  = $clog2(WIDTH),
    localparam int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              clear,
    input  logic              en,
    input  logic              mode,
    input  logic              start,
    input  logic [ADDR_W-1:0] sel,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    output logic              out,
    output logic [CNT_W-1:0]  bit_idx,
    output logic              frame_start,
    output logic              busy,
    output logic              done
);

    localparam logic [CNT_W-1:0] C_LAST_BIT = CNT_W'(WIDTH - 1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [WIDTH-1:0]   r_shadow;
    logic [WIDTH-1:0]   w_shadow_nxt;
    logic               r_done;
    logic               w_done_nxt;
    logic [WIDTH-1:0]   w_table [DEPTH];
    logic [WIDTH-1:0]   w_sel_data;
    logic [CNT_W-1:0]   w_bit_pos;
    logic               w_busy;

    // Thermometer code for entry k: lowest min(k+1, WIDTH) bits set.
    function automatic logic [WIDTH-1:0] therm(input int k);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < WIDTH; i++) begin
            v[i] = (i <= k);
        end
        return v;
    endfunction

    for (genvar k = 0; k < DEPTH; k++) begin : g_entry
        localparam logic [WIDTH-1:0] C_THERM = therm(k);
        logic [WIDTH-1:0] r_entry;

        always_ff @(posedge clk or posedge clear) begin
            if (clear) begin
                r_entry <= C_THERM;
            end else if (wr_en && (wr_addr == ADDR_W'(k))) begin
                r_entry <= wr_data;
            end
        end

        assign w_table[k] = r_entry;
    end

    // Loads read the pre-edge table contents, so a same-edge write is not seen.
    assign w_sel_data = w_table[sel];

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_shadow <= w_shadow_nxt;
            r_done   <= w_done_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_shadow_nxt = r_shadow;
        w_done_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (en && (!mode || start)) begin
                    w_state_nxt  = ST_RUN;
                    w_cnt_nxt    = '0;
                    w_shadow_nxt = w_sel_data;
                end
            end
            ST_RUN: begin
                if (en) begin
                    if (r_cnt == C_LAST_BIT) begin
                        w_cnt_nxt = '0;
                        if (mode) begin
                            w_state_nxt = ST_IDLE;
                            w_done_nxt  = 1'b1;
                        end else begin
                            w_shadow_nxt = w_sel_data;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

`ifdef SPG_MSB_FIRST_EN
    assign w_bit_pos = C_LAST_BIT - r_cnt;
`else
    assign w_bit_pos = r_cnt;
`endif

    assign w_busy      = (r_state == ST_RUN);
    assign busy        = w_busy;
    assign out         = w_busy & r_shadow[w_bit_pos];
    assign bit_idx     = r_cnt;
    assign frame_start = w_busy & (r_cnt == '0);
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_pattern_gen
// Brief    : Self-checking bench for serial_pattern_gen (default 8x8 table).
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_gen;

    logic       clk = 1'b0;
    logic       clear = 1'b1;
    logic       en = 1'b0;
    logic       mode = 1'b0;
    logic       start = 1'b0;
    logic [2:0] sel = 3'd0;
    logic       wr_en = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [7:0] wr_data = 8'h00;
    logic       out;
    logic [2:0] bit_idx;
    logic       frame_start;
    logic       busy;
    logic       done;

    int checks = 0;
    int failures = 0;
    int step = 0;

    typedef struct packed {
        logic       en;
        logic       mode;
        logic       start;
        logic [2:0] sel;
        logic       wr_en;
        logic [2:0] wr_addr;
        logic [7:0] wr_data;
        logic       busy;
        logic [2:0] idx;
        logic [7:0] pat;
        logic       done;
    } vec_t;

    vec_t vecs[$];
    vec_t exp_q[$];

    serial_pattern_gen #(.WIDTH(8), .ADDR_W(3)) dut (
        .clk         (clk),
        .clear       (clear),
        .en          (en),
        .mode        (mode),
        .start       (start),
        .sel         (sel),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .out         (out),
        .bit_idx     (bit_idx),
        .frame_start (frame_start),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s step=%0d: got %0h expected %0h (t=%0t)", name, step, act, req, $time);
        end
    endtask

    function automatic logic exp_bit(input logic [7:0] p, input logic [2:0] i);
        logic [2:0] pos;
`ifdef SPG_MSB_FIRST_EN
        pos = 3'd7 - i;
`else
        pos = i;
`endif
        return p[pos];
    endfunction

    function automatic vec_t mk(input logic e, input logic m, input logic s, input logic [2:0] sl,
                                input logic we, input logic [2:0] wa, input logic [7:0] wd,
                                input logic b, input logic [2:0] ix, input logic [7:0] p,
                                input logic d);
        vec_t v;
        v = '{en: e, mode: m, start: s, sel: sl, wr_en: we, wr_addr: wa, wr_data: wd,
              busy: b, idx: ix, pat: p, done: d};
        return v;
    endfunction

    task automatic add(input logic e, input logic m, input logic s, input logic [2:0] sl,
                       input logic we, input logic [2:0] wa, input logic [7:0] wd,
                       input logic b, input logic [2:0] ix, input logic [7:0] p, input logic d);
        vecs.push_back(mk(e, m, s, sl, we, wa, wd, b, ix, p, d));
    endtask

    // Drive one cycle of inputs, then compare the outputs that edge produces.
    task automatic apply(input vec_t v);
        vec_t e;
        en      = v.en;
        mode    = v.mode;
        start   = v.start;
        sel     = v.sel;
        wr_en   = v.wr_en;
        wr_addr = v.wr_addr;
        wr_data = v.wr_data;
        exp_q.push_back(v);
        @(negedge clk);
        e = exp_q.pop_front();
        step++;
        check("busy", 32'(busy), 32'(e.busy));
        check("done", 32'(done), 32'(e.done));
        check("bit_idx", 32'(bit_idx), e.busy ? 32'(e.idx) : 32'd0);
        check("out", 32'(out), e.busy ? 32'(exp_bit(e.pat, e.idx)) : 32'd0);
        check("frame_start", 32'(frame_start), 32'(e.busy && (e.idx == 3'd0)));
    endtask

    task automatic oneshot(input logic [2:0] s, input logic [7:0] p);
        apply(mk(1, 1, 1, s, 0, 0, 8'h00, 1, 3'd0, p, 0));
        for (int k = 1; k < 8; k++) begin
            apply(mk(1, 1, 0, s, 0, 0, 8'h00, 1, 3'(k), p, 0));
        end
        apply(mk(1, 1, 0, s, 0, 0, 8'h00, 0, 3'd0, 8'h00, 1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_out"}, 32'(out), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_bit_idx"}, 32'(bit_idx), 32'd0);
        check({tag, "_frame_start"}, 32'(frame_start), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_idle_outputs("reset");
        clear = 1'b0;

        // Continuous sel=2 (07); sel moves to 5 at bit 3, takes effect next frame (3F).
        for (int k = 0; k < 3; k++) add(1, 0, 0, 3'd2, 0, 0, 8'h00, 1, 3'(k), 8'h07, 0);
        for (int k = 3; k < 8; k++) add(1, 0, 0, 3'd5, 0, 0, 8'h00, 1, 3'(k), 8'h07, 0);
        for (int k = 0; k < 4; k++) add(1, 0, 0, 3'd5, 0, 0, 8'h00, 1, 3'(k), 8'h3F, 0);
        // Mode goes one-shot mid-frame: frame still completes, then done.
        for (int k = 4; k < 8; k++) add(1, 1, 0, 3'd5, 0, 0, 8'h00, 1, 3'(k), 8'h3F, 0);
        add(1, 1, 0, 3'd7, 0, 0, 8'h00, 0, 3'd0, 8'h00, 1);
        add(1, 1, 0, 3'd7, 0, 0, 8'h00, 0, 3'd0, 8'h00, 0);
        // One-shot sel=7; start held into RUN is ignored.
        add(1, 1, 1, 3'd7, 0, 0, 8'h00, 1, 3'd0, 8'hFF, 0);
        add(1, 1, 1, 3'd7, 0, 0, 8'h00, 1, 3'd1, 8'hFF, 0);
        for (int k = 2; k < 8; k++) add(1, 1, 0, 3'd7, 0, 0, 8'h00, 1, 3'(k), 8'hFF, 0);
        add(1, 1, 0, 3'd7, 0, 0, 8'h00, 0, 3'd0, 8'h00, 1);
        add(1, 1, 0, 3'd7, 0, 0, 8'h00, 0, 3'd0, 8'h00, 0);
        // Pause for 3 cycles at bit 4 of 1F.
        add(1, 1, 1, 3'd4, 0, 0, 8'h00, 1, 3'd0, 8'h1F, 0);
        for (int k = 1; k < 5; k++) add(1, 1, 0, 3'd4, 0, 0, 8'h00, 1, 3'(k), 8'h1F, 0);
        for (int k = 0; k < 3; k++) add(0, 1, 0, 3'd4, 0, 0, 8'h00, 1, 3'd4, 8'h1F, 0);
        for (int k = 5; k < 8; k++) add(1, 1, 0, 3'd4, 0, 0, 8'h00, 1, 3'(k), 8'h1F, 0);
        add(1, 1, 0, 3'd4, 0, 0, 8'h00, 0, 3'd0, 8'h00, 1);
        // Retrigger in the done cycle, colliding with a write of A5 to entry 1.
        add(1, 1, 1, 3'd1, 1, 3'd1, 8'hA5, 1, 3'd0, 8'h03, 0);
        for (int k = 1; k < 8; k++) add(1, 0, 0, 3'd1, 0, 0, 8'h00, 1, 3'(k), 8'h03, 0);
        for (int k = 0; k < 8; k++) add(1, 0, 0, 3'd1, 0, 0, 8'h00, 1, 3'(k), 8'hA5, 0);
        // Pause on the last bit, then end as one-shot; start with en=0 not queued.
        add(0, 1, 1, 3'd1, 0, 0, 8'h00, 1, 3'd7, 8'hA5, 0);
        add(1, 1, 0, 3'd1, 0, 0, 8'h00, 0, 3'd0, 8'h00, 1);
        add(0, 1, 1, 3'd1, 0, 0, 8'h00, 0, 3'd0, 8'h00, 0);
        add(1, 1, 0, 3'd1, 0, 0, 8'h00, 0, 3'd0, 8'h00, 0);

        foreach (vecs[i]) apply(vecs[i]);

        // Reset mid-frame: immediate idle outputs, no done, table restored.
        apply(mk(1, 0, 0, 3'd1, 0, 0, 8'h00, 1, 3'd0, 8'hA5, 0));
        apply(mk(1, 0, 0, 3'd1, 1, 3'd3, 8'h00, 1, 3'd1, 8'hA5, 0));
        #2 clear = 1'b1;
        #1 check_idle_outputs("clear_async");
        @(negedge clk);
        check_idle_outputs("clear_held");
        clear = 1'b0;
        oneshot(3'd1, 8'h03);
        oneshot(3'd3, 8'h0F);
        oneshot(3'd0, 8'h01);

        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/serial_pattern_gen.md
# serial_pattern_gen

Parametrised serial pattern generator: holds a table of `DEPTH` patterns of `WIDTH` bits and shifts the selected pattern out one bit per clock. It sits between control logic and a single-bit serial output. It extends the fixed 8x8 thermometer generator with the following:
- a writable pattern table;
- frame-aligned pattern selection;
- one-shot and continuous modes;
- an enable/pause control;
- frame and done strobes.

## Interface
- `WIDTH`, 8, bits per pattern; must be ≥2. `CNT_W = $clog2(WIDTH)`.
- `ADDR_W`, 3, table address width; `DEPTH = 2**ADDR_W` entries.

- `clk`  in  1  rising-edge clock.
- `clear`  in  1  asynchronous, active-high reset.
- `en`  in  1  run enable; low pauses the generator.
- `mode`  in  1  0 = continuous, 1 = one-shot.
- `start`  in  1  one-shot trigger; sampled in IDLE only.
- `sel`  in  ADDR_W  pattern select; sampled only at frame load.
- `wr_en`  in  1  table write strobe.
- `wr_addr`  in  ADDR_W  table write address.
- `wr_data`  in  WIDTH  table write data.
- `out`  out  1  serial data bit.
- `bit_idx`  out  CNT_W  index of the bit currently on `out`.
- `frame_start`  out  1  high while bit 0 of a frame is on `out`.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse after the last bit of a one-shot frame.

## Operation
- **State machine.** States are IDLE and RUN. The internal bit counter is `cnt` (CNT_W bits, drives `bit_idx`). The frame register is `shadow` (WIDTH bits).
- **Frame load.** A load is `shadow <= table[sel]`, `cnt <= 0`.
- **IDLE → RUN.** Requires `en=1`, plus either `mode=0`, or `mode=1` with `start=1`. The same edge performs a frame load.
- **RUN, `en=0`.** `cnt`, `shadow` and state hold. `out` keeps its value.
- **RUN, `en=1`, `cnt < WIDTH-1`.** `cnt <= cnt+1`.
- **RUN, `en=1`, `cnt == WIDTH-1`, `mode=0`.** Frame load from the current `sel`; stay in RUN. There is no gap between frames.
- **RUN, `en=1`, `cnt == WIDTH-1`, `mode=1`.** Go to IDLE, `cnt <= 0`, `done <= 1` for exactly one cycle.
- **Mode changes.** `mode` is evaluated only at the last bit, so changing it mid-frame takes effect at the frame end.
- **`out`.** Combinational: `shadow[cnt]` in RUN, 0 in IDLE.
- **`frame_start`.** `busy & (cnt == 0)`.
- **`sel` changes mid-frame.** No effect until the next frame load.
- **Table writes.** Occur on any edge where `wr_en=1`, in any state.
  - If a write and a load hit the same entry on the same edge, the load takes the old contents.
  - `shadow` is never modified by writes.
- **Reset (`clear=1`, asynchronous).**
  - State → IDLE; `cnt`, `shadow`, `done` → 0.
  - `out`, `busy`, `frame_start`, `bit_idx` → 0.
  - Table reloads the thermometer contents: entry k = lowest min(k+1, WIDTH) bits set. For the defaults this is 01, 03, 07, 0F, 1F, 3F, 7F, FF.
  - Reset mid-frame aborts the frame with no `done`.
- **`start` handling.** `start` is ignored in RUN; `start` with `en=0` is ignored (not queued).

## Timing
- **Load-to-output latency.** On load edge N, bit 0 appears on `out` in the cycle after N. Bit k appears k enabled cycles later.
- **Frame length.** WIDTH enabled cycles. Pause cycles stretch the frame without dropping or repeating bits.
- **`done`.** Registered. High during the single cycle after the edge that leaves RUN, coinciding with `busy=0`.
- **Earliest one-shot retrigger.** If `start` is high during the `done` cycle, the next frame loads on that edge. Minimum spacing between frames is one idle cycle.
- **Reset release.** First load possible on the first rising edge with `clear=0`.

## Configuration
- **`SPG_MSB_FIRST_EN` defined:** bit order is reversed. `out = shadow[WIDTH-1-cnt]`; `bit_idx` still counts 0..WIDTH-1.
- **`SPG_MSB_FIRST_EN` not defined (default):** LSB-first, `out = shadow[cnt]`.
- The macro affects only the output bit order. Table contents, timing and strobes are identical in both builds.

## Test plan
- **Reset / thermometer check.** Apply `clear`; then `mode=0`, `en=1`, `sel=2`. Required: `out` = 1,1,1,0,0,0,0,0 repeating; `frame_start` high every 8th cycle.
- **Frame-aligned select.** Change `sel` 2→5 at bit 3. Required: current frame completes as 07. The next frame is 3F (1,1,1,1,1,1,0,0).
- **One-shot.** `mode=1`, `sel=7`, pulse `start`. Required: eight 1s, then `busy=0` with one-cycle `done`, then `out=0`. `start` asserted during RUN has no effect.
- **Pause.** Drop `en` for 3 cycles at bit 4. Required: `bit_idx` holds at 4 and `out` holds. The frame resumes with no lost or duplicated bit.
- **Write collision.** Write 8'hA5 to entry `sel` on the load edge. Required: that frame uses the old value; the next frame emits A5 as 1,0,1,0,0,1,0,1.
- **Reset mid-frame and MSB-first build.** Assert `clear` mid-frame. Required: immediate `out=0`, `busy=0`, no `done`, and written entries are restored to thermometer values. With `SPG_MSB_FIRST_EN`, `sel=0` emits 0,0,0,0,0,0,0,1.
